// File: rtl/multicycle_control_pkg.sv
// mc_pkg: shared opcodes, FSM states and datapath select encodings for the multi-cycle control unit
package mc_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT} state_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    function automatic logic is_known(input logic [6:0] op);
        return op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM};
    endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/memory status in, datapath strobes, selects and counters out
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [6:0]       opcode;
    logic             bcond;
    logic             halt_cond;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_class;
    logic             reg_write;
    logic             mem_to_reg;
    logic             pc_to_reg;
    logic             illegal_inst;
    logic             bus_error;
    logic             is_halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    modport slave (
        input  opcode, bcond, halt_cond, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_class, reg_write, mem_to_reg, pc_to_reg,
               illegal_inst, bus_error, is_halted, cycle_count, instret_count
    );

    modport master (
        output opcode, bcond, halt_cond, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_class, reg_write, mem_to_reg, pc_to_reg,
               illegal_inst, bus_error, is_halted, cycle_count, instret_count
    );
endinterface

// File: rtl/multicycle_control_perf_counter.sv
// mc_perf_counter: wrapping CNT_W-bit event counter with enable
module mc_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q;

    // count enabled cycles, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else if (en_i) count_q <= count_q + CNT_W'(1);
    end

    assign count_o = count_q;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with perf counters and memory timeout
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.slave  bus
);
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] LIMIT = WW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q;
    logic            bus_error_q, halted_q;
    logic            waiting, timeout, retire;

    assign waiting = state_q inside {S_FETCH, S_MEMORY};
    // the last permitted stall cycle without mem_ready ends the access; a late ready still completes it
    assign timeout = (MEM_TIMEOUT != 0) && waiting && !bus.mem_ready && wait_q == LIMIT;
    assign retire  = bus.pc_write || (state_d == S_HALT && state_q != S_HALT);

    // decode strobes/selects from state and opcode; everything is forced low while reset is held
    always_comb begin
        state_d          = state_q;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_source    = PC_PLUS4;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = SRCB_RS2;
        bus.alu_class    = ALU_ADD;
        bus.reg_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;
        bus.pc_to_reg    = 1'b0;
        bus.illegal_inst = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    if (timeout) state_d = S_HALT;
                    else if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        state_d      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM;
                    if (bus.opcode == SYSTEM && bus.halt_cond) state_d = S_HALT;
                    else if (bus.opcode == SYSTEM || !is_known(bus.opcode)) begin
                        bus.illegal_inst = !is_known(bus.opcode);
                        bus.pc_write     = 1'b1;
                        state_d          = S_FETCH;
                    end else state_d = S_EXECUTE;
                end
                S_EXECUTE: begin
                    bus.alu_src_a = bus.opcode inside {BRANCH, LOAD, STORE, OP, OP_IMM, JALR};
                    bus.alu_src_b = bus.opcode inside {BRANCH, OP} ? SRCB_RS2 : SRCB_IMM;
                    bus.alu_class = bus.opcode == BRANCH ? ALU_BRANCH :
                                    bus.opcode inside {OP, OP_IMM} ? ALU_FUNCT : ALU_ADD;
                    bus.pc_write  = bus.opcode == BRANCH;
                    bus.pc_source = (bus.opcode == BRANCH && bus.bcond) ? PC_ALUOUT : PC_PLUS4;
                    state_d       = bus.opcode == BRANCH ? S_FETCH :
                                    bus.opcode inside {LOAD, STORE} ? S_MEMORY : S_WRITEBACK;
                end
                S_MEMORY: begin
                    bus.i_or_d    = 1'b1;
                    bus.mem_read  = bus.opcode == LOAD;
                    bus.mem_write = bus.opcode == STORE;
                    if (timeout) state_d = S_HALT;
                    else if (bus.mem_ready) begin
                        bus.pc_write = bus.opcode == STORE;
                        state_d      = bus.opcode == LOAD ? S_WRITEBACK : S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = bus.opcode == LOAD;
                    bus.pc_to_reg  = bus.opcode inside {JAL, JALR};
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = bus.opcode == JAL ? PC_ALUOUT : bus.opcode == JALR ? PC_ALU : PC_PLUS4;
                    bus.alu_src_a  = bus.opcode == JALR;
                    bus.alu_src_b  = bus.opcode == JALR ? SRCB_IMM : SRCB_RS2;
                    state_d        = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    // state, memory wait counter and sticky halt/bus-error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            bus_error_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= (waiting && !bus.mem_ready) ? wait_q + WW'(1) : '0;
            if (timeout) bus_error_q <= 1'b1;
            if (state_d == S_HALT) halted_q <= 1'b1;
        end
    end

    assign bus.bus_error = bus_error_q;
    assign bus.is_halted = halted_q;

    mc_perf_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q != S_HALT),
        .count_o (bus.cycle_count)
    );

    mc_perf_counter #(.CNT_W(CNT_W)) u_instret (
        .clk     (clk),
        .reset   (reset),
        .en_i    (retire),
        .count_o (bus.instret_count)
    );
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model driving random programs against the control unit
module tb_multicycle_control;
    import mc_pkg::*;

    localparam int CNT_W = 4;
    localparam int TO    = 4;

    typedef struct packed {
        logic       mem_read, mem_write, iod_care, i_or_d, ir_write, pc_write;
        logic [1:0] pc_source;
        logic       src_care, alu_src_a;
        logic [1:0] alu_src_b;
        logic       cls_care;
        logic [1:0] alu_class;
        logic       reg_write, mem_to_reg, pc_to_reg, illegal, to_halt, bus;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t ex;
    logic chk_en = 1'b0;
    int   m_cyc, m_ret, n_chk, n_fail;
    logic m_halt, m_bus;
    logic [6:0] ops [11] = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, 7'h7F};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // compare every scripted cycle against the instruction-level expectation
    always @(negedge clk) if (chk_en) begin
        chk("mem_read", bus.mem_read, ex.mem_read);
        chk("mem_write", bus.mem_write, ex.mem_write);
        if (ex.iod_care) chk("i_or_d", bus.i_or_d, ex.i_or_d);
        chk("ir_write", bus.ir_write, ex.ir_write);
        chk("pc_write", bus.pc_write, ex.pc_write);
        if (ex.pc_write) chk("pc_source", bus.pc_source, ex.pc_source);
        if (ex.src_care) begin
            chk("alu_src_a", bus.alu_src_a, ex.alu_src_a);
            chk("alu_src_b", bus.alu_src_b, ex.alu_src_b);
        end
        if (ex.cls_care) chk("alu_class", bus.alu_class, ex.alu_class);
        chk("reg_write", bus.reg_write, ex.reg_write);
        chk("mem_to_reg", bus.mem_to_reg, ex.mem_to_reg);
        chk("pc_to_reg", bus.pc_to_reg, ex.pc_to_reg);
        chk("illegal_inst", bus.illegal_inst, ex.illegal);
        chk("bus_error", bus.bus_error, m_bus);
        chk("is_halted", bus.is_halted, m_halt);
        chk("cycle_count", bus.cycle_count, m_cyc % (1 << CNT_W));
        chk("instret_count", bus.instret_count, m_ret % (1 << CNT_W));
    end

    task automatic step(input logic rdy, input logic [6:0] op, input logic bc, input logic hc, input exp_t e);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.bcond     = bc;
        bus.halt_cond = hc;
        ex            = e;
        chk_en        = 1'b1;
        @(posedge clk);
        chk_en = 1'b0;
        if (!m_halt) m_cyc++;
        if (e.pc_write || e.to_halt) m_ret++;
        if (e.to_halt) m_halt = 1'b1;
        if (e.bus) m_bus = 1'b1;
        #1;
    endtask

    // one instruction: fs/ms are stall cycles before mem_ready in fetch/memory
    task automatic exec_inst(input logic [6:0] op, input logic bc, input logic hc, input int fs, input int ms, input bit abort);
        exp_t e;
        bit ld, st;
        ld = op == LOAD;
        st = op == STORE;
        for (int k = 0; k <= fs; k++) begin
            e = '0; e.mem_read = 1'b1; e.iod_care = 1'b1;
            if (k == fs) begin
                e.ir_write = 1'b1;
                step(1'b1, 7'($urandom), rb(), rb(), e);
            end else if (k == TO - 1) begin
                e.to_halt = 1'b1; e.bus = 1'b1;
                step(1'b0, 7'($urandom), rb(), rb(), e);
                return;
            end else step(1'b0, 7'($urandom), rb(), rb(), e);
        end
        e = '0; e.src_care = 1'b1; e.alu_src_b = 2'd2; e.cls_care = 1'b1;
        if (op == SYSTEM) begin
            if (hc) e.to_halt = 1'b1; else e.pc_write = 1'b1;
            step(rb(), op, rb(), hc, e);
            return;
        end
        if (!(op inside {OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC})) begin
            e.illegal = 1'b1; e.pc_write = 1'b1;
            step(rb(), op, rb(), hc, e);
            return;
        end
        step(rb(), op, rb(), hc, e);
        e = '0;
        if (op == BRANCH) begin
            e.src_care = 1'b1; e.alu_src_a = 1'b1; e.cls_care = 1'b1; e.alu_class = 2'd1;
            e.pc_write = 1'b1; e.pc_source = bc ? 2'd1 : 2'd0;
            step(rb(), op, bc, rb(), e);
            return;
        end
        if (ld || st) begin e.src_care = 1'b1; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; end
        if (op == OP || op == OP_IMM) begin e.cls_care = 1'b1; e.alu_class = 2'd2; end
        step(rb(), op, rb(), rb(), e);
        if (ld || st) begin
            for (int k = 0; k <= ms; k++) begin
                e = '0; e.iod_care = 1'b1; e.i_or_d = 1'b1; e.mem_read = ld; e.mem_write = st;
                if (k == ms) begin
                    e.pc_write = st;
                    step(1'b1, op, rb(), rb(), e);
                    if (st) return;
                end else if (k == TO - 1) begin
                    e.to_halt = 1'b1; e.bus = 1'b1;
                    step(1'b0, op, rb(), rb(), e);
                    return;
                end else begin
                    step(1'b0, op, rb(), rb(), e);
                    if (abort) return;
                end
            end
        end
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = ld; e.pc_to_reg = op == JAL || op == JALR;
        e.pc_write = 1'b1; e.pc_source = op == JAL ? 2'd1 : op == JALR ? 2'd2 : 2'd0;
        step(rb(), op, rb(), rb(), e);
    endtask

    task automatic halt_cycles(input int n);
        repeat (n) step(rb(), 7'($urandom), rb(), rb(), '0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_is_halted", bus.is_halted, 0);
        chk("rst_bus_error", bus.bus_error, 0);
        chk("rst_cycle_count", bus.cycle_count, 0);
        chk("rst_instret", bus.instret_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cyc = 0; m_ret = 0; m_halt = 1'b0; m_bus = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] op;
        int fs, ms;
        n_chk = 0; n_fail = 0;
        bus.opcode = '0; bus.bcond = 1'b0; bus.halt_cond = 1'b0; bus.mem_ready = 1'b0;
        do_reset();
        exec_inst(OP_IMM, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("addi_cycles", bus.cycle_count, 4);
        chk("addi_instret", bus.instret_count, 1);
        do_reset();
        exec_inst(LOAD, 1'b0, 1'b0, 3, 3, 1'b0);
        chk("lw_cycles", bus.cycle_count, 11);
        chk("lw_instret", bus.instret_count, 1);
        exec_inst(BRANCH, 1'b1, 1'b0, 0, 0, 1'b0);
        exec_inst(BRANCH, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("beq_cycles_wrapped", bus.cycle_count, 1);
        exec_inst(7'h7F, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("illegal_instret", bus.instret_count, 4);
        exec_inst(SYSTEM, 1'b0, 1'b1, 0, 0, 1'b0);
        chk("ecall_halted", bus.is_halted, 1);
        halt_cycles(10);
        chk("halt_cycles_frozen", bus.cycle_count, 5);
        do_reset();
        exec_inst(OP, 1'b0, 1'b0, 10, 0, 1'b0);
        chk("timeout_bus_error", bus.bus_error, 1);
        chk("timeout_halted", bus.is_halted, 1);
        chk("timeout_cycles", bus.cycle_count, 4);
        halt_cycles(3);
        do_reset();
        repeat (17) exec_inst(SYSTEM, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("wrap_instret", bus.instret_count, 1);
        chk("wrap_cycles", bus.cycle_count, 2);
        do_reset();
        exec_inst(STORE, 1'b0, 1'b0, 0, 5, 1'b1);
        bus.mem_ready = 1'b0;
        #2;
        chk("store_mem_write_before_reset", bus.mem_write, 1);
        reset = 1'b1;
        #1;
        chk("store_mem_write_in_reset", bus.mem_write, 0);
        chk("store_i_or_d_in_reset", bus.i_or_d, 0);
        chk("store_mem_read_in_reset", bus.mem_read, 0);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halt) begin
                halt_cycles(2);
                do_reset();
            end
            op = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 15) == 0) op = 7'($urandom);
            fs = ($urandom_range(0, 11) == 0) ? 6 : $urandom_range(0, 3);
            ms = ($urandom_range(0, 11) == 0) ? 6 : $urandom_range(0, 3);
            exec_inst(op, rb(), $urandom_range(0, 9) == 0, fs, ms, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
